pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Program-counter and fetch sequencer, the consumer of the branch unit's redirect
//  request (taken flag + 11-bit target). Holds the PC and drives the instruction-
//  memory address. Applies redirects, flushes younger pipeline stages, and keeps a
//  small return-address stack (RAS) for call/return. Sits between branch resolution
//  (execute stage) and instruction memory (fetch stage).
// PARAMETERS
//  ADDR_W     11  PC / imem address width; matches the branch unit's 11-bit target
//  RAS_DEPTH  4   return-address stack entries (power of 2, >=2)
//  FLUSH_LEN  2   bubble cycles inserted after an accepted redirect (1..7)
// PORTS
//  clk            in   1       clock; all state changes on rising edge
//  rst            in   1       synchronous, active-high reset
//  stall          in   1       hazard stall; freezes PC, RAS, and the flush counter
//  br_taken       in   1       redirect request from branch unit (level, one cycle)
//  br_target      in   ADDR_W  redirect target (imm or register source)
//  br_call        in   1       with br_taken: push link_in onto RAS
//  br_ret         in   1       with br_taken: target taken from RAS top, pop
//  link_in        in   ADDR_W  return address to push (call instr addr + 1)
//  imem_addr      out  ADDR_W  current PC = instruction-memory address
//  fetch_valid    out  1       imem_addr is a valid fetch this cycle
//  flush          out  1       kill younger (fetch/decode) instructions
//  ras_overflow   out  1       sticky: push attempted on full RAS
//  ras_underflow  out  1       sticky: pop attempted on empty RAS
// BEHAVIOUR
//  Reset (rst=1 at edge): PC=0, state=S_BOOT, RAS empty (count=0),
//   flush=0, fetch_valid=0, both sticky flags=0. Reset mid-redirect aborts it.
//  States:
//   S_BOOT: one cycle, fetch_valid=0, PC holds 0; then go to S_RUN (stall ignored).
//   S_RUN: fetch_valid=1, flush=0.
//    - stall=1: hold everything; br_* inputs ignored. Decode re-presents them.
//    - stall=0 & br_taken=1: accept the redirect. PC <= resolved target.
//      Load flush counter with FLUSH_LEN. Go to S_REDIRECT.
//    - stall=0 & br_taken=0: PC <= PC+1 mod 2^ADDR_W (0x7FF -> 0x000).
//   S_REDIRECT: flush=1, fetch_valid=0, PC held at target, br_* ignored.
//    - Counter decrements each non-stall cycle.
//    - On the cycle it reads 1 and stall=0: go to S_RUN.
//    - First valid fetch of the target occurs FLUSH_LEN+1 cycles after acceptance.
//  Target resolution (only on acceptance):
//   - br_ret=1, RAS non-empty: target=RAS top; pop.
//   - br_ret=1, RAS empty: target=br_target; set ras_underflow.
//   - br_call=1: target=br_target; push link_in.
//     If the RAS is full, discard the push, keep contents, set ras_overflow.
//   - br_call & br_ret both 1: treat as ret only (no push); set ras_underflow if empty.
//   - br_call/br_ret with br_taken=0: ignored.
//  RAS is a LIFO with an up/down pointer and count 0..RAS_DEPTH.
//   It is not circular: overflow never overwrites.
//  Sticky flags clear only on rst.
//  All outputs are registered or decoded from state. No combinational path from
//   br_* to imem_addr.
// TESTING
//  1 rst 1 cycle then run: cycle1 fetch_valid=0, then imem_addr 0,1,2,3 with
//    fetch_valid=1.
//  2 at PC=5, br_taken=1, target=0x040 (FLUSH_LEN=2): flush=1 for 2 cycles,
//    then imem_addr=0x040 valid, then 0x041.
//  3 call target=0x100, link_in=0x011; later ret (br_target=0x3FF):
//    PC=0x011, RAS empty after.
//  4 5 calls with RAS_DEPTH=4: ras_overflow=1 after 5th. 4 rets return the
//    first 4 links in LIFO order. 5th ret uses br_target and sets ras_underflow.
//  5 stall=1 with br_taken=1 at PC=0x020 for 3 cycles: PC stays 0x020, no flush.
//    Release: redirect accepted once.
//  6 PC=0x7FF, no branch -> 0x000. rst asserted during S_REDIRECT -> next cycle
//    S_BOOT, PC=0, flush=0.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: branch-unit redirect inputs and fetch-side outputs of the PC sequencer
interface pc_sequencer_if #(parameter int ADDR_W = 11);
  logic              stall;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic              br_call;
  logic              br_ret;
  logic [ADDR_W-1:0] link_in;
  logic [ADDR_W-1:0] imem_addr;
  logic              fetch_valid;
  logic              flush;
  logic              ras_overflow;
  logic              ras_underflow;
  modport master (
    output stall, br_taken, br_target, br_call, br_ret, link_in,
    input  imem_addr, fetch_valid, flush, ras_overflow, ras_underflow
  );
  modport slave (
    input  stall, br_taken, br_target, br_call, br_ret, link_in,
    output imem_addr, fetch_valid, flush, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with redirect/flush sequencing and a return-address stack
module pc_sequencer #(
  parameter int ADDR_W    = 11,
  parameter int RAS_DEPTH = 4,
  parameter int FLUSH_LEN = 2
) (
  input  logic clk,
  input  logic rst,
  pc_sequencer_if.slave bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_REDIRECT} state_t;
  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx, target;
  logic [ADDR_W-1:0] ras [RAS_DEPTH];
  logic [CW-1:0]     cnt;
  logic [2:0]        fcnt;
  logic              accept, ras_empty, ras_full, do_pop, do_push, set_under, set_over;
  always_comb begin
    accept    = state == S_RUN && !bus.stall && bus.br_taken;
    ras_empty = cnt == '0;
    ras_full  = cnt == CW'(RAS_DEPTH);
    do_pop    = accept && bus.br_ret && !ras_empty;
    set_under = accept && bus.br_ret && ras_empty;
    do_push   = accept && bus.br_call && !bus.br_ret && !ras_full;
    set_over  = accept && bus.br_call && !bus.br_ret && ras_full;
    target    = do_pop ? ras[PW'(cnt - 1'b1)] : bus.br_target;
    pc_nx     = accept ? target : (state == S_RUN && !bus.stall) ? pc + 1'b1 : pc;
    state_nx  = state;
    case (state)
      S_BOOT:     state_nx = S_RUN;
      S_RUN:      state_nx = accept ? S_REDIRECT : S_RUN;
      S_REDIRECT: state_nx = (!bus.stall && fcnt == 3'd1) ? S_RUN : S_REDIRECT;
      default:    state_nx = S_BOOT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) state <= S_BOOT;
    else     state <= state_nx;
  end
  // The flush counter only advances on non-stalled cycles so the bubble count is exact.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc                <= '0;
      cnt               <= '0;
      fcnt              <= '0;
      bus.ras_overflow  <= 1'b0;
      bus.ras_underflow <= 1'b0;
    end else begin
      pc <= pc_nx;
      if (accept) fcnt <= 3'(FLUSH_LEN);
      else if (state == S_REDIRECT && !bus.stall) fcnt <= fcnt - 1'b1;
      if (do_push) begin
        ras[PW'(cnt)] <= bus.link_in;
        cnt           <= cnt + 1'b1;
      end else if (do_pop) cnt <= cnt - 1'b1;
      if (set_over)  bus.ras_overflow  <= 1'b1;
      if (set_under) bus.ras_underflow <= 1'b1;
    end
  end
  assign bus.imem_addr   = pc;
  assign bus.fetch_valid = state == S_RUN;
  assign bus.flush       = state == S_REDIRECT;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors for pc_sequencer (ADDR_W=11, RAS_DEPTH=4, FLUSH_LEN=2)
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  pc_sequencer_if #(.ADDR_W(11)) bus ();
  pc_sequencer #(.ADDR_W(11), .RAS_DEPTH(4), .FLUSH_LEN(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.br_taken = 0; bus.br_call = 0; bus.br_ret = 0;
  endtask
  // Issue one accepted redirect and ride out the flush; ends in S_RUN at the target.
  task automatic redirect(input logic c, input logic r, input logic [10:0] t, input logic [10:0] l);
    bus.br_taken = 1; bus.br_call = c; bus.br_ret = r; bus.br_target = t; bus.link_in = l;
    step();
    idle();
    step();
    step();
  endtask
  initial begin
    rst = 1; bus.stall = 0; bus.br_target = '0; bus.link_in = '0;
    idle();
    step();
    chk("rst_pc", 32'(bus.imem_addr), 0);
    chk("rst_fv", 32'(bus.fetch_valid), 0);
    chk("rst_flush", 32'(bus.flush), 0);
    chk("rst_ovf", 32'(bus.ras_overflow), 0);
    chk("rst_unf", 32'(bus.ras_underflow), 0);
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("boot_fv", 32'(bus.fetch_valid), 1);
      chk("boot_pc", 32'(bus.imem_addr), 32'(i));
    end
    bus.br_taken = 1; bus.br_target = 11'h040;
    step();
    idle();
    chk("br_flush1", 32'(bus.flush), 1);
    chk("br_fv1", 32'(bus.fetch_valid), 0);
    step();
    chk("br_flush2", 32'(bus.flush), 1);
    step();
    chk("br_flush_end", 32'(bus.flush), 0);
    chk("br_tgt", 32'(bus.imem_addr), 32'h040);
    chk("br_tgt_fv", 32'(bus.fetch_valid), 1);
    step();
    chk("br_tgt1", 32'(bus.imem_addr), 32'h041);
    redirect(1, 0, 11'h100, 11'h011);
    chk("call_pc", 32'(bus.imem_addr), 32'h100);
    redirect(0, 1, 11'h3FF, 11'h000);
    chk("ret_pc", 32'(bus.imem_addr), 32'h011);
    chk("ret_unf", 32'(bus.ras_underflow), 0);
    for (int i = 1; i <= 5; i++) begin
      redirect(1, 0, 11'(32'h200 + i), 11'(32'h100 + i));
      chk("calls_pc", 32'(bus.imem_addr), 32'h200 + 32'(i));
      chk("calls_ovf", 32'(bus.ras_overflow), i == 5 ? 1 : 0);
    end
    for (int i = 4; i >= 1; i--) begin
      redirect(0, 1, 11'h3FF, 11'h000);
      chk("rets_pc", 32'(bus.imem_addr), 32'h100 + 32'(i));
      chk("rets_unf", 32'(bus.ras_underflow), 0);
    end
    redirect(1, 1, 11'h055, 11'h066);
    chk("ret_empty_pc", 32'(bus.imem_addr), 32'h055);
    chk("ret_empty_unf", 32'(bus.ras_underflow), 1);
    redirect(0, 1, 11'h077, 11'h000);
    chk("callret_nopush", 32'(bus.imem_addr), 32'h077);
    redirect(0, 0, 11'h01E, 11'h000);
    step();
    step();
    chk("pre_stall_pc", 32'(bus.imem_addr), 32'h020);
    bus.stall = 1; bus.br_taken = 1; bus.br_target = 11'h0AB;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", 32'(bus.imem_addr), 32'h020);
      chk("stall_flush", 32'(bus.flush), 0);
    end
    bus.stall = 0;
    step();
    idle();
    chk("rel_flush", 32'(bus.flush), 1);
    step();
    bus.stall = 1;
    step();
    chk("redir_stall_flush", 32'(bus.flush), 1);
    bus.stall = 0;
    step();
    chk("rel_pc", 32'(bus.imem_addr), 32'h0AB);
    chk("rel_fv", 32'(bus.fetch_valid), 1);
    step();
    chk("rel_once", 32'(bus.imem_addr), 32'h0AC);
    redirect(0, 0, 11'h7FE, 11'h000);
    step();
    chk("wrap_pre", 32'(bus.imem_addr), 32'h7FF);
    step();
    chk("wrap_pc", 32'(bus.imem_addr), 32'h000);
    bus.br_taken = 1; bus.br_target = 11'h123;
    step();
    idle();
    chk("mid_flush", 32'(bus.flush), 1);
    rst = 1;
    step();
    rst = 0;
    chk("mid_rst_pc", 32'(bus.imem_addr), 0);
    chk("mid_rst_flush", 32'(bus.flush), 0);
    chk("mid_rst_fv", 32'(bus.fetch_valid), 0);
    chk("mid_rst_ovf", 32'(bus.ras_overflow), 0);
    chk("mid_rst_unf", 32'(bus.ras_underflow), 0);
    step();
    chk("post_rst_fv", 32'(bus.fetch_valid), 1);
    chk("post_rst_pc", 32'(bus.imem_addr), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
